instr_fetch_buffer: RTL and testbench

//  Consumer side of the program-counter interface: takes the fetch address from program_counter,

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/instr_fetch_buffer.sv | 149 ++++++++++++++
 tb/tb_instr_fetch_buffer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction fetch buffer.
package fetch_pkg;

  localparam int unsigned FETCH_DEPTH  = 4;
  localparam int unsigned FETCH_ADDR_W = 32;
  localparam int unsigned FETCH_DATA_W = 32;

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a synchronous clear and an occupancy output.
// A pop and a push may happen in the same cycle, including at full and at
// empty; an empty FIFO shows a pushed word on the following cycle only.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH,
  parameter int unsigned W     = $bits(fetch_entry_t)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic [W-1:0]           wdata_i,
  input  logic                   pop_i,
  output logic [W-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          pop_ok;
  logic          push_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage array; a clear discards the word being written that cycle.
  always_ff @(posedge clk) begin
    if (push_ok && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // The producer's credit scheme must never push into a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !pop_ok && !clear_i && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: issues in-order memory requests at the current
// PC, tags each with its PC, buffers returned words and presents them to
// decode. A taken branch flushes buffered words and drops the responses of
// requests already in flight.
// Optional feature macro: FETCH_PERF_EN adds perf_stall_cnt/perf_flush_cnt.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high; valid never depends on ready. imem request fires on
// imem_req_valid && imem_req_ready, decode takes the head on
// instr_valid && instr_ready (ignored in a br_taken cycle).
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = FETCH_DEPTH,
  parameter int unsigned ADDR_W = FETCH_ADDR_W,
  parameter int unsigned DATA_W = FETCH_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              br_taken,
  output logic              pc_hold,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              fetch_flush_ack
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = ADDR_W + DATA_W;
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

  fetch_state_e      state_q;
  logic [CW-1:0]     drop_cnt_q;
  logic [CW-1:0]     drop_cnt_d;
  logic              ack_q;
  logic [CW-1:0]     count;
  logic [CW-1:0]     outstanding;
  logic [CW:0]       credit_used;
  logic              req_fire;
  logic              rsp_ok;
  logic              rsp_drop;
  logic              data_push;
  logic              data_pop;
  logic [ADDR_W-1:0] tag_head;
  logic [EW-1:0]     data_head;

  // Every in-flight request and every buffered word holds one credit.
  assign credit_used    = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = (state_q == FETCH) && !br_taken && (credit_used < CREDIT_MAX);
  assign imem_req_addr  = imem_req_valid ? pc_in : '0;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign pc_hold        = !req_fire;

  // A response with nothing outstanding cannot be matched to a tag; ignore it.
  assign rsp_ok    = imem_rsp_valid && (outstanding != '0);
  assign rsp_drop  = rsp_ok && (drop_cnt_q != '0);
  assign data_push = rsp_ok && !rsp_drop;
  assign data_pop  = instr_valid && instr_ready && !br_taken;

  assign instr_valid     = (count != '0);
  assign instr_pc        = instr_valid ? data_head[EW-1:DATA_W] : '0;
  assign instr_out       = instr_valid ? data_head[DATA_W-1:0] : '0;
  assign fetch_flush_ack = ack_q;

  // Drop budget: a branch reloads it with whatever is still in flight.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (br_taken) begin
      drop_cnt_d = outstanding - CW'(rsp_ok);
    end else if (rsp_drop) begin
      drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  // Control FSM with the drop counter and the flush acknowledge pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      drop_cnt_q <= '0;
      ack_q      <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      ack_q      <= br_taken;
      case (state_q)
        IDLE:    state_q <= FETCH;
        FETCH,
        DRAIN:   state_q <= (drop_cnt_d != '0) ? DRAIN : FETCH;
        default: state_q <= IDLE;
      endcase
    end
  end

  // In-order PC tags of issued requests; kept across a flush so that
  // dropped responses still retire their tags.
  fetch_fifo #(.DEPTH(DEPTH), .W(ADDR_W)) u_tag_q (
    .clk     (clk),
    .rst     (reset),
    .clear_i (1'b0),
    .push_i  (req_fire),
    .wdata_i (pc_in),
    .pop_i   (rsp_ok),
    .rdata_o (tag_head),
    .count_o (outstanding)
  );

  // Buffered {pc, instr} words waiting for decode.
  fetch_fifo #(.DEPTH(DEPTH), .W(EW)) u_data_q (
    .clk     (clk),
    .rst     (reset),
    .clear_i (br_taken),
    .push_i  (data_push),
    .wdata_i ({tag_head, imem_rsp_data}),
    .pop_i   (data_pop),
    .rdata_o (data_head),
    .count_o (count)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  // Saturating counters of held fetch cycles and of branch flushes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if ((state_q == FETCH) && pc_hold && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (br_taken && (flush_q != '1)) flush_q <= flush_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_q;
  assign perf_flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: a program-counter model, an in-order memory
// model with random latency, and a decode-side scoreboard. Decode must see
// exactly the PCs the fetch stream issued since the last branch, in order,
// each with the word memory holds at that PC.
module tb_instr_fetch_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] pc_in;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              pc_hold;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] instr_pc;
  logic              fetch_flush_ack;
`ifdef FETCH_PERF_EN
  logic [31:0]       perf_stall_cnt;
  logic [31:0]       perf_flush_cnt;
  int unsigned       stall_m;
  int unsigned       flush_m;
`endif

  // Counters and knobs
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_pops = 0;
  int lat_lo = 1, lat_hi = 1, ready_pct = 100, req_pct = 100, br_pct = 0;
  bit force_br = 1'b0;
  logic [ADDR_W-1:0] force_tgt = '0;

  // Reference model state
  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] mem_addr_q[$];
  int                mem_due_q[$];
  int                last_due = 0;
  int                stale = 0;
  int                buffered = 0;
  bit                idle = 1'b1;
  logic              prev_br = 1'b0;
  logic [ADDR_W-1:0] pc_nxt = '0;

  always #5 clk = ~clk;

  instr_fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_in           (pc_in),
    .br_taken        (br_taken),
    .pc_hold         (pc_hold),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_out       (instr_out),
    .instr_pc        (instr_pc),
    .fetch_flush_ack (fetch_flush_ack)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt)
`endif
  );

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_inputs();
    pc_in = pc_nxt;
    if (force_br) begin
      br_taken  = 1'b1;
      br_target = force_tgt;
      force_br  = 1'b0;
    end else begin
      br_taken  = (int'($urandom_range(0, 99)) < br_pct);
      br_target = ADDR_W'($urandom_range(0, 32'h3FFF)) << 2;
    end
    instr_ready    = (int'($urandom_range(0, 99)) < ready_pct);
    imem_req_ready = (int'($urandom_range(0, 99)) < req_pct);
    if (mem_addr_q.size() != 0 && mem_due_q[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_addr_q[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    drive_inputs();
  endtask

  // Reset is held for two edges and released just after an edge; on
  // return the bench is in cycle 0 (the IDLE cycle).
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc++;
    drive_inputs();
  endtask

  // ---------------- compare process / scoreboard ----------------
  always @(negedge clk) begin
    logic fire_m;
    logic pop;
    logic exp_req;
    logic [ADDR_W-1:0] head_pc;
    int due;
    if (reset) begin
      chk("rst_pc_hold", pc_hold, 1'b1);
      chk("rst_req_valid", imem_req_valid, 1'b0);
      chk("rst_req_addr", imem_req_addr, '0);
      chk("rst_instr_valid", instr_valid, 1'b0);
      chk("rst_instr_out", instr_out, '0);
      chk("rst_instr_pc", instr_pc, '0);
      chk("rst_ack", fetch_flush_ack, 1'b0);
`ifdef FETCH_PERF_EN
      chk("rst_perf_stall", perf_stall_cnt, 0);
      chk("rst_perf_flush", perf_flush_cnt, 0);
      stall_m = 0;
      flush_m = 0;
`endif
      exp_q.delete();
      mem_addr_q.delete();
      mem_due_q.delete();
      last_due = 0;
      stale = 0;
      buffered = 0;
      idle = 1'b1;
      prev_br = 1'b0;
      pc_nxt = '0;
    end else begin
      // Fetch may issue only when not flushing/draining and a credit is free.
      exp_req = !idle && (stale == 0) && !br_taken && ((mem_addr_q.size() + buffered) < DEPTH);
      fire_m  = exp_req && imem_req_ready;
      pop     = instr_valid && instr_ready && !br_taken;
      chk("req_valid", imem_req_valid, exp_req);
      chk("pc_hold", pc_hold, !fire_m);
      if (imem_req_valid) chk("req_addr", imem_req_addr, pc_in);
      chk("flush_ack", fetch_flush_ack, prev_br);
      chk("instr_valid", instr_valid, buffered != 0);
`ifdef FETCH_PERF_EN
      chk("perf_stall", perf_stall_cnt, stall_m);
      chk("perf_flush", perf_flush_cnt, flush_m);
      if (!idle && stale == 0 && !fire_m) stall_m++;
      if (br_taken) flush_m++;
`endif
      if (pop) begin
        chk("pop_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          head_pc = exp_q.pop_front();
          chk("instr_pc", instr_pc, head_pc);
          chk("instr_out", instr_out, mem_word(head_pc));
          n_pops++;
        end
        if (buffered > 0) buffered--;
      end
      if (imem_rsp_valid && mem_addr_q.size() != 0) begin
        void'(mem_addr_q.pop_front());
        void'(mem_due_q.pop_front());
        if (stale > 0) stale--;
        else if (!br_taken) buffered++;
      end
      if (imem_req_valid && imem_req_ready) begin
        due = cyc + int'($urandom_range(lat_lo, lat_hi));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_addr_q.push_back(imem_req_addr);
        mem_due_q.push_back(due);
        exp_q.push_back(pc_in);
      end
      if (br_taken) begin
        exp_q.delete();
        buffered = 0;
        stale = mem_addr_q.size();
      end
      pc_nxt  = br_taken ? br_target : (!pc_hold ? pc_in + 32'd4 : pc_in);
      prev_br = br_taken;
      idle    = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  int ph_lat_lo[4] = '{1, 1, 2, 1};
  int ph_lat_hi[4] = '{1, 4, 5, 3};
  int ph_ready[4]  = '{100, 60, 25, 90};
  int ph_req[4]    = '{100, 80, 70, 100};
  int ph_br[4]     = '{0, 4, 8, 2};

  initial begin
    reset = 1'b1;
    br_taken = 1'b0;
    br_target = '0;
    pc_in = '0;
    instr_ready = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;

    // Streaming with 1-cycle memory: PCs 0,4,8 reach decode from cycle 3.
    lat_lo = 1; lat_hi = 1; ready_pct = 100; req_pct = 100; br_pct = 0;
    do_reset();
    tick(); tick(); tick();
    #2;
    chk("t1_valid_c3", instr_valid, 1'b1);
    chk("t1_pc_c3", instr_pc, 32'h0);
    chk("t1_data_c3", instr_out, mem_word(32'h0));
    tick(); #2;
    chk("t1_pc_c4", instr_pc, 32'h4);
    tick(); #2;
    chk("t1_pc_c5", instr_pc, 32'h8);

    // Decode stalled: four requests fill the buffer, then fetch holds.
    ready_pct = 0;
    do_reset();
    repeat (8) tick();
    #2;
    chk("t2_req_valid_full", imem_req_valid, 1'b0);
    chk("t2_pc_hold_full", pc_hold, 1'b1);
    chk("t2_valid_full", instr_valid, 1'b1);
    chk("t2_head_full", instr_pc, 32'h0);
    ready_pct = 100;
    for (int i = 0; i < 4; i++) begin
      tick(); #2;
      chk("t2_drain_pc", instr_pc, 32'(i * 4));
    end

    // Asynchronous reset in the middle of a cycle with words buffered.
    ready_pct = 0;
    repeat (3) tick();
    #1;
    reset = 1'b1;
    #1;
    chk("t5_valid_async", instr_valid, 1'b0);
    chk("t5_hold_async", pc_hold, 1'b1);
    chk("t5_req_async", imem_req_valid, 1'b0);
    chk("t5_pc_async", instr_pc, 32'h0);

    // Branch with two requests in flight at latency 3.
    lat_lo = 3; lat_hi = 3; ready_pct = 100;
    do_reset();
    tick(); tick();
    force_br = 1'b1; force_tgt = 32'h100;
    tick();
    #2;
    chk("t3_no_req_on_br", imem_req_valid, 1'b0);
    tick(); #2;
    chk("t3_ack_pulse", fetch_flush_ack, 1'b1);
    chk("t3_valid_c4", instr_valid, 1'b0);
    tick(); #2;
    chk("t3_ack_low", fetch_flush_ack, 1'b0);
    chk("t3_valid_c5", instr_valid, 1'b0);
    tick(); #2;
    chk("t3_req_target", imem_req_valid, 1'b1);
    chk("t3_addr_target", imem_req_addr, 32'h100);
    repeat (3) begin
      tick(); #2;
      chk("t3_no_stale", instr_valid, 1'b0);
    end
    tick(); #2;
    chk("t3_first_pc", instr_pc, 32'h100);
    chk("t3_first_data", instr_out, mem_word(32'h100));

    // Randomized phases; each starts from a reset issued mid-stream.
    for (int p = 0; p < 4; p++) begin
      lat_lo = ph_lat_lo[p]; lat_hi = ph_lat_hi[p];
      ready_pct = ph_ready[p]; req_pct = ph_req[p]; br_pct = ph_br[p];
      do_reset();
      repeat (1000) tick();
    end
    #2;
    chk("progress_pops", n_pops > 500, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
